// File: rtl/sc_seq_pkg.sv
// Shared types and helpers for the sc_computer I/O test sequencer.
// Optional polling compare is enabled with SC_SEQ_POLL_EN.
package sc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_DUT,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } seq_state_e;

  localparam int CMP_W = 1024;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Operands are zero-extended to CMP_W by the caller.
  function automatic logic masked_miss(
    input logic [CMP_W-1:0] act,
    input logic [CMP_W-1:0] want,
    input logic [CMP_W-1:0] mask
  );
    return |((act ^ want) & mask);
  endfunction

endpackage

// File: rtl/sc_seq_vec_ram.sv
// Vector table: synchronous write, combinational read.
// Contents are intentionally not reset.
module sc_seq_vec_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sc_io_test_sequencer.sv
// Stimulus/check sequencer for sc_computer I/O ports.
// Define SC_SEQ_POLL_EN for polling compare and timeout_count.
module sc_io_test_sequencer
  import sc_seq_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int NUM_IN        = 2,
  parameter int NUM_OUT       = 3,
  parameter int DEPTH         = 16,
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(DEPTH):0]      num_vec,
  input  logic                        vec_we,
  input  logic [$clog2(DEPTH)-1:0]    vec_addr,
  input  logic [NUM_IN*DATA_W-1:0]    vec_in,
  input  logic [NUM_OUT*DATA_W-1:0]   vec_exp,
  input  logic [NUM_OUT*DATA_W-1:0]   vec_mask,
  input  logic [NUM_OUT*DATA_W-1:0]   dut_out,
  output logic                        dut_resetn,
  output logic [NUM_IN*DATA_W-1:0]    dut_in,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [$clog2(DEPTH):0]      fail_count,
  output logic [$clog2(DEPTH)-1:0]    first_fail,
  output logic [31:0]                 cycle_count
`ifdef SC_SEQ_POLL_EN
  ,
  output logic [$clog2(DEPTH):0]      timeout_count
`endif
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int IN_W  = NUM_IN * DATA_W;
  localparam int OUT_W = NUM_OUT * DATA_W;
  localparam int ROW_W = IN_W + 2 * OUT_W;

  seq_state_e state, nxt;

  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] nv;
  logic [CNT_W-1:0] nv_clamp;
  logic [31:0]      tmr;
  logic             tmr_zero;
  logic             last;
  logic             mism;
  logic             fail;
  logic             poll_hit;

  logic [ROW_W-1:0] ent;
  logic [IN_W-1:0]  ent_in;
  logic [OUT_W-1:0] ent_exp;
  logic [OUT_W-1:0] ent_mask;

  logic go, tmr_dec, rel, apply, chk, fin;

  sc_seq_vec_ram #(
    .DEPTH (DEPTH),
    .W     (ROW_W)
  ) u_ram (
    .clock (clock),
    .we    (vec_we && !busy),
    .waddr (vec_addr),
    .wdata ({vec_mask, vec_exp, vec_in}),
    .raddr (idx),
    .rdata (ent)
  );

  assign ent_in   = ent[IN_W-1:0];
  assign ent_exp  = ent[IN_W+OUT_W-1:IN_W];
  assign ent_mask = ent[ROW_W-1:IN_W+OUT_W];

  assign mism = masked_miss(CMP_W'(dut_out),
                            CMP_W'(ent_exp),
                            CMP_W'(ent_mask));

  assign tmr_zero = (tmr == 32'd0);
  assign last     = ({1'b0, idx} == nv - CNT_W'(1));
  assign nv_clamp = (num_vec > CNT_W'(DEPTH)) ?
                    CNT_W'(DEPTH) : num_vec;
  assign pass     = done && (fail_count == '0);

`ifdef SC_SEQ_POLL_EN
  logic poll_ok;
  assign poll_hit = !mism;
  assign fail     = !poll_ok;
`else
  assign poll_hit = 1'b0;
  assign fail     = mism;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RST_DUT;
      DONE:    if (start) nxt = RST_DUT;
      RST_DUT: if (tmr_zero)
                 nxt = (nv == '0) ? DONE : APPLY;
      APPLY:   nxt = SETTLE;
      SETTLE:  if (tmr_zero || poll_hit) nxt = CHECK;
      CHECK:   nxt = last ? DONE : APPLY;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    go      = 1'b0;
    tmr_dec = 1'b0;
    rel     = 1'b0;
    apply   = 1'b0;
    chk     = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE, DONE: go = start;
      RST_DUT: begin
        tmr_dec = !tmr_zero;
        rel     = tmr_zero;
        fin     = tmr_zero && (nv == '0);
      end
      APPLY:  apply   = 1'b1;
      SETTLE: tmr_dec = !tmr_zero;
      CHECK: begin
        chk = 1'b1;
        fin = last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dut_resetn  <= 1'b0;
      dut_in      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail_count  <= '0;
      first_fail  <= '0;
      cycle_count <= '0;
      idx         <= '0;
      nv          <= '0;
      tmr         <= '0;
    end else begin
      if (busy && dut_resetn && cycle_count != '1)
        cycle_count <= cycle_count + 32'd1;
      if (tmr_dec) tmr <= tmr - 32'd1;
      if (rel) dut_resetn <= 1'b1;
      if (apply) begin
        dut_in <= ent_in;
        tmr    <= 32'(SETTLE_CYCLES - 1);
      end
      if (chk) begin
        if (fail) begin
          fail_count <= fail_count + CNT_W'(1);
          if (fail_count == '0) first_fail <= idx;
        end
        if (!last) idx <= idx + IDX_W'(1);
      end
      if (fin) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (go) begin
        busy        <= 1'b1;
        done        <= 1'b0;
        dut_resetn  <= 1'b0;
        nv          <= nv_clamp;
        idx         <= '0;
        fail_count  <= '0;
        first_fail  <= '0;
        cycle_count <= '0;
        tmr         <= 32'(RESET_CYCLES - 1);
      end
    end
  end

`ifdef SC_SEQ_POLL_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      poll_ok       <= 1'b0;
      timeout_count <= '0;
    end else begin
      if (state == SETTLE) poll_ok <= !mism;
      if (chk && !poll_ok)
        timeout_count <= timeout_count + CNT_W'(1);
      if (go) timeout_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_sc_io_test_sequencer.sv
// Directed bench for sc_io_test_sequencer with an adder model DUT.
// Define SC_SEQ_POLL_EN to exercise the polling compare build.
module tb_sc_io_test_sequencer;

`ifdef SC_SEQ_POLL_EN
  localparam int PV = 3;
`else
  localparam int PV = 66;
`endif
  localparam int FV = 66;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  num_vec;
  logic        vec_we;
  logic [3:0]  vec_addr;
  logic [63:0] vec_in;
  logic [95:0] vec_exp;
  logic [95:0] vec_mask;
  logic [95:0] dut_out;
  logic        dut_resetn;
  logic [63:0] dut_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail;
  logic [31:0] cycle_count;
`ifdef SC_SEQ_POLL_EN
  logic [4:0]  timeout_count;
`endif

  int ncmp = 0;
  int nbad = 0;

  always #5 clock = ~clock;

  logic [31:0] sum;
  logic [31:0] out0;
  assign sum = dut_in[31:0] + dut_in[63:32];

`ifdef SC_SEQ_POLL_EN
  bit          slow = 1'b0;
  logic [31:0] pipe [4];
  always @(posedge clock) begin
    pipe[0] <= sum;
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign out0 = slow ? pipe[3] : sum;
`else
  assign out0 = sum;
`endif

  assign dut_out = {64'h0, out0};

  sc_io_test_sequencer #(
    .DATA_W        (32),
    .NUM_IN        (2),
    .NUM_OUT       (3),
    .DEPTH         (16),
    .RESET_CYCLES  (4),
    .SETTLE_CYCLES (64)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_vec     (num_vec),
    .vec_we      (vec_we),
    .vec_addr    (vec_addr),
    .vec_in      (vec_in),
    .vec_exp     (vec_exp),
    .vec_mask    (vec_mask),
    .dut_out     (dut_out),
    .dut_resetn  (dut_resetn),
    .dut_in      (dut_in),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_count  (fail_count),
    .first_fail  (first_fail),
    .cycle_count (cycle_count)
`ifdef SC_SEQ_POLL_EN
    ,
    .timeout_count (timeout_count)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    ncmp++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic load(input int a,
                      input logic [31:0] i0,
                      input logic [31:0] i1,
                      input logic [31:0] e0,
                      input logic [31:0] m0);
    @(posedge clock); #1;
    vec_we   = 1'b1;
    vec_addr = a[3:0];
    vec_in   = {i1, i0};
    vec_exp  = {32'h0, 32'hDEAD_BEEF, e0};
    vec_mask = {64'h0, m0};
    @(posedge clock); #1;
    vec_we   = 1'b0;
  endtask

  task automatic run(input logic [4:0] nv, input bit poke,
                     output int lat, output int rlow,
                     output bit ok);
    @(posedge clock); #1;
    num_vec = nv;
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0; rlow = 0; ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy && !dut_resetn) rlow++;
      if (poke && k == 2) begin
        start    = 1'b1;
        vec_we   = 1'b1;
        vec_addr = 4'd0;
        vec_exp  = {64'h0, 32'h55};
        vec_mask = '1;
      end
      @(posedge clock); #1;
      start  = 1'b0;
      vec_we = 1'b0;
      lat++;
    end
  endtask

  int lat, rlow;
  bit ok;

  initial begin
    reset = 1'b1; start = 1'b0; num_vec = '0;
    vec_we = 1'b0; vec_addr = '0; vec_in = '0;
    vec_exp = '0; vec_mask = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_resetn", 64'(dut_resetn), 64'd0);
    chk("rst_busy",   64'(busy),       64'd0);
    chk("rst_done",   64'(done),       64'd0);
    chk("rst_pass",   64'(pass),       64'd0);
    chk("rst_fcnt",   64'(fail_count), 64'd0);
    chk("rst_cyc",    64'(cycle_count), 64'd0);
    chk("rst_din",    64'(dut_in),     64'd0);

    // single vector 3+7 = 10
    load(0, 3, 7, 10, 32'hFFFF_FFFF);
    run(5'd1, 1'b0, lat, rlow, ok);
    chk("v1_ok",   64'(ok),          64'd1);
    chk("v1_lat",  64'(lat),         64'(4 + PV));
    chk("v1_rlow", 64'(rlow),        64'd4);
    chk("v1_pass", 64'(pass),        64'd1);
    chk("v1_fcnt", 64'(fail_count),  64'd0);
    chk("v1_cyc",  64'(cycle_count), 64'(PV));
    chk("v1_din",  64'(dut_in),      64'h7_0000_0003);
    chk("v1_rstn", 64'(dut_resetn),  64'd1);
    chk("v1_busy", 64'(busy),        64'd0);

    // three vectors, vector 1 expects 11 but gets 10
    load(0, 1, 2, 3,  32'hFFFF_FFFF);
    load(1, 4, 6, 11, 32'hFFFF_FFFF);
    load(2, 5, 5, 10, 32'hFFFF_FFFF);
    run(5'd3, 1'b0, lat, rlow, ok);
    chk("v3_ok",   64'(ok),          64'd1);
    chk("v3_lat",  64'(lat),         64'(4 + 2 * PV + FV));
    chk("v3_fcnt", 64'(fail_count),  64'd1);
    chk("v3_ff",   64'(first_fail),  64'd1);
    chk("v3_pass", 64'(pass),        64'd0);
    chk("v3_cyc",  64'(cycle_count), 64'(2 * PV + FV));
`ifdef SC_SEQ_POLL_EN
    chk("v3_tmo",  64'(timeout_count), 64'd1);
`endif

    // reset during SETTLE of vector 2
    @(posedge clock); #1;
    num_vec = 5'd3;
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (cycle_count == 32'(PV + FV + 1)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mr_reach", 64'(ok),         64'd1);
    chk("mr_ff_pre", 64'(first_fail), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mr_busy",  64'(busy),        64'd0);
    chk("mr_done",  64'(done),        64'd0);
    chk("mr_rstn",  64'(dut_resetn),  64'd0);
    chk("mr_fcnt",  64'(fail_count),  64'd0);
    chk("mr_ff",    64'(first_fail),  64'd0);
    chk("mr_cyc",   64'(cycle_count), 64'd0);
    chk("mr_din",   64'(dut_in),      64'd0);
    reset = 1'b0;
    run(5'd3, 1'b0, lat, rlow, ok);
    chk("rr_ok",   64'(ok),          64'd1);
    chk("rr_lat",  64'(lat),         64'(4 + 2 * PV + FV));
    chk("rr_fcnt", 64'(fail_count),  64'd1);
    chk("rr_ff",   64'(first_fail),  64'd1);
    chk("rr_cyc",  64'(cycle_count), 64'(2 * PV + FV));

    // zero vectors
    run(5'd0, 1'b0, lat, rlow, ok);
    chk("z_ok",   64'(ok),          64'd1);
    chk("z_lat",  64'(lat),         64'd4);
    chk("z_rlow", 64'(rlow),        64'd4);
    chk("z_pass", 64'(pass),        64'd1);
    chk("z_rstn", 64'(dut_resetn),  64'd1);
    chk("z_cyc",  64'(cycle_count), 64'd0);

    // low-nibble mask; start and write while busy are ignored
    load(0, 4, 6, 32'hFFFF_FFFA, 32'h0000_000F);
    run(5'd1, 1'b1, lat, rlow, ok);
    chk("m_ok",   64'(ok),   64'd1);
    chk("m_lat",  64'(lat),  64'(4 + PV));
    chk("m_pass", 64'(pass), 64'd1);
    run(5'd1, 1'b0, lat, rlow, ok);
    chk("m2_pass", 64'(pass), 64'd1);

    // num_vec above DEPTH clamps to 16, last entry wrong
    for (int i = 0; i < 16; i++)
      load(i, i, 1, (i == 15) ? 99 : i + 1, 32'hFFFF_FFFF);
    run(5'd31, 1'b0, lat, rlow, ok);
    chk("c_ok",   64'(ok),          64'd1);
    chk("c_lat",  64'(lat),         64'(4 + 15 * PV + FV));
    chk("c_fcnt", 64'(fail_count),  64'd1);
    chk("c_ff",   64'(first_fail),  64'd15);
    chk("c_cyc",  64'(cycle_count), 64'(15 * PV + FV));
    chk("c_din",  64'(dut_in),      64'h1_0000_000F);

`ifdef SC_SEQ_POLL_EN
    // slow DUT: match appears 5 clocks after APPLY
    slow = 1'b1;
    load(0, 2, 2, 4, 32'hFFFF_FFFF);
    run(5'd1, 1'b0, lat, rlow, ok);
    chk("p_ok",   64'(ok),            64'd1);
    chk("p_lat",  64'(lat),           64'd11);
    chk("p_cyc",  64'(cycle_count),   64'd7);
    chk("p_pass", 64'(pass),          64'd1);
    chk("p_tmo",  64'(timeout_count), 64'd0);
    load(0, 2, 2, 5, 32'hFFFF_FFFF);
    run(5'd1, 1'b0, lat, rlow, ok);
    chk("t_fcnt", 64'(fail_count),    64'd1);
    chk("t_tmo",  64'(timeout_count), 64'd1);
    chk("t_cyc",  64'(cycle_count),   64'd66);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/sc_io_test_sequencer.md
Name: sc_io_test_sequencer

Overview:
- Synthesizable, parametrised stimulus and check sequencer for the single-cycle computer's I/O ports.
- Drives the DUT's active-low reset and NUM_IN input ports from a loadable vector table.
- After each vector, compares the masked DUT output ports against expected values and accumulates pass/fail results.
- Sits beside sc_computer on the FPGA or in simulation, replacing fixed hand-set input values and a single timed output print.

Parameters:
- DATA_W, 32: width of each in/out port.
- NUM_IN, 2: number of DUT input ports driven.
- NUM_OUT, 3: number of DUT output ports checked.
- DEPTH, 16: vector table entries (power of two).
- RESET_CYCLES, 4: clocks dut_resetn is held low at run start.
- SETTLE_CYCLES, 64: clocks between applying a vector and comparing; must be ≥1.

Ports:
- clock  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- num_vec  in  $clog2(DEPTH)+1  vectors to run, 0..DEPTH, sampled at start.
- vec_we  in  1  table write strobe; honoured only when busy=0.
- vec_addr  in  $clog2(DEPTH)  table write address.
- vec_in  in  NUM_IN*DATA_W  input values for the entry.
- vec_exp  in  NUM_OUT*DATA_W  expected output values.
- vec_mask  in  NUM_OUT*DATA_W  compare mask; 1 = bit is checked.
- dut_out  in  NUM_OUT*DATA_W  DUT out_port0..N-1, concatenated with port 0 in the LSBs.
- dut_resetn  out  1  active-low reset to the DUT.
- dut_in  out  NUM_IN*DATA_W  DUT in_port0..N-1, concatenated with port 0 in the LSBs.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- pass  out  1  done with fail_count==0.
- fail_count  out  $clog2(DEPTH)+1  mismatching vectors.
- first_fail  out  $clog2(DEPTH)  index of the first mismatch.
- cycle_count  out  32  clocks since dut_resetn was released; saturates at 2^32-1.

Behaviour:
- Reset values: dut_resetn=0, dut_in=0, busy=0, done=0, pass=0, fail_count=0, first_fail=0, cycle_count=0, state=IDLE. The table contents are not reset.
- IDLE: dut_resetn=0. start moves to RST_DUT, latches num_vec, clears all counters and flags, and raises busy on the next cycle.
- RST_DUT: hold dut_resetn=0 for exactly RESET_CYCLES clocks. Then set dut_resetn=1 and go to APPLY.
- APPLY, one cycle: drive dut_in from entry idx (idx starts at 0), load the settle counter, go to SETTLE. dut_in holds its value until the next APPLY.
- SETTLE: wait SETTLE_CYCLES clocks, then go to CHECK.
- CHECK, one cycle: a mismatch is any bit where (dut_out ^ exp) & mask is nonzero.
  - On mismatch: increment fail_count; if it was 0, set first_fail=idx.
  - If idx==num_vec-1, go to DONE; otherwise increment idx and go to APPLY.
- The DUT is not reset between vectors; its state carries across them.
- num_vec==0: go RST_DUT → DONE with pass=1.
- num_vec>DEPTH: clamp to DEPTH.
- DONE: busy=0, done=1, pass=(fail_count==0). dut_resetn stays 1 and dut_in holds its last value. start re-runs from RST_DUT.
- start while busy: ignored.
- vec_we while busy: ignored, with no table write.
- reset mid-run: immediately returns to the reset values above; a partially run sequence is discarded.
- cycle_count increments every clock while dut_resetn=1 and busy=1.
- Per-vector latency: 1 (APPLY) + SETTLE_CYCLES + 1 (CHECK) clocks. Vector 0 is preceded by RESET_CYCLES.

Optional Feature:
- Macro: SC_SEQ_POLL_EN.
- When defined, SETTLE becomes a polling state that evaluates the compare every clock:
  - On match: go to CHECK immediately and record a pass.
  - If SETTLE_CYCLES clocks pass without a match: go to CHECK and record a fail.
  - Adds output `timeout_count`, width $clog2(DEPTH)+1, counting vectors that failed by timeout.
- When undefined: fixed-delay compare only, and the timeout_count port does not exist.

Decomposition:
- Package sc_seq_pkg holds:
  - state enum: IDLE, RST_DUT, APPLY, SETTLE, CHECK, DONE;
  - localparam-style width helpers (IDX_W = $clog2(DEPTH), CNT_W = IDX_W+1);
  - the masked-compare function.
- One sub-module, sc_seq_vec_ram: DEPTH x (NUM_IN+2*NUM_OUT)*DATA_W table with a synchronous write port and a combinational read port.

Test Plan:
- Single vector {in0=3, in1=7}, exp out0=10 with mask out0=all-1 and other masks 0; DUT adds in0+in1 → done=1, pass=1, fail_count=0 after 4+1+64+1 clocks.
- Three vectors where vector 1 expects out0=11 but the DUT gives 10 → fail_count=1, first_fail=1, pass=0.
- Mask out0=0x0000000F, exp=0xFFFFFFFA, dut_out0=0x0000000A → pass=1.
- num_vec=0 with start → done=1, pass=1, and dut_resetn low for exactly 4 clocks.
- Assert reset during SETTLE of vector 2 → all outputs return to reset values next edge; a restart runs from vector 0 with fail_count=0.
- With SC_SEQ_POLL_EN: DUT output matches 5 clocks after APPLY → CHECK entered at clock 6 and pass. A DUT that never matches → timeout_count=1 and fail_count=1.
